poly1305_sequencer: RTL and testbench

- Initiator and driver for processblock: accepts a one-time key (r, s) and a 32-bit little-endian message stream.
- Assembles 16-byte blocks and applies Poly1305 padding.
- Issues one start pulse per block, waits for done, and feeds the accumulator back as a_in.
- Performs final reduction mod P = 2^130−5, adds s, and emits the 128-bit tag.
- processblock is instantiated outside this block and wired to the pb_* ports.

---
 rtl/poly1305_pkg.sv | 20 ++
 rtl/poly1305_sequencer_if.sv | 44 ++++
 rtl/poly1305_finalize.sv | 15 +
 rtl/poly1305_sequencer.sv | 133 +++++++++++++
 tb/tb_poly1305_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly1305_pkg.sv
// Constants and helpers shared by the Poly1305 sequencer and its finalize stage.
package poly1305_pkg;

    localparam logic [129:0] P          = 130'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
    localparam logic [127:0] CLAMP_MASK = 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff;
    localparam int           BLOCK_BYTES = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FINAL = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    // A full block (n == 16) lands the pad bit at m[128]; a partial block gets 0x01 at byte n.
    function automatic logic [128:0] pad_block(input logic [127:0] blk, input logic [4:0] n);
        return {1'b0, blk} | (129'd1 << {n, 3'b000});
    endfunction

endpackage

// File: rtl/poly1305_sequencer_if.sv
// Key, message, tag and processblock signals of the Poly1305 sequencer.
interface poly1305_sequencer_if;

    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_r;
    logic [127:0] key_s;

    logic         msg_valid;
    logic         msg_ready;
    logic [31:0]  msg_data;
    logic [2:0]   msg_bytes;
    logic         msg_last;

    logic         tag_valid;
    logic         tag_ready;
    logic [127:0] tag;

    logic [127:0] pb_r;
    logic [128:0] pb_m;
    logic [129:0] pb_a_in;
    logic         pb_start;
    logic         pb_done;
    logic [129:0] pb_a_out;

    // The sequencer side.
    modport master (
        input  key_valid, key_r, key_s,
        input  msg_valid, msg_data, msg_bytes, msg_last,
        input  tag_ready, pb_done, pb_a_out,
        output key_ready, msg_ready, tag_valid, tag,
        output pb_r, pb_m, pb_a_in, pb_start
    );

    // The host and processblock side.
    modport slave (
        output key_valid, key_r, key_s,
        output msg_valid, msg_data, msg_bytes, msg_last,
        output tag_ready, pb_done, pb_a_out,
        input  key_ready, msg_ready, tag_valid, tag,
        input  pb_r, pb_m, pb_a_in, pb_start
    );

endinterface

// File: rtl/poly1305_finalize.sv
// Final Poly1305 step: reduce the accumulator once mod P, add s, keep the low 128 bits.
module poly1305_finalize (
    input  logic [129:0] i_acc,
    input  logic [127:0] i_s,
    output logic [127:0] o_tag
);
    import poly1305_pkg::*;

    logic [129:0] w_reduced;

    // acc < 2^130 < 2P, so a single conditional subtraction is a full reduction.
    assign w_reduced = (i_acc >= P) ? (i_acc - P) : i_acc;
    assign o_tag     = 128'(w_reduced + {2'b00, i_s});

endmodule

// File: rtl/poly1305_sequencer.sv
// Poly1305 driver: packs the message into padded 16-byte blocks, runs each through an
// external processblock unit, chains the accumulator and emits the final tag.
module poly1305_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    poly1305_sequencer_if.master bus
);
    import poly1305_pkg::*;

    logic [2:0]   r_state;
    logic [127:0] r_r;
    logic [127:0] r_s;
    logic [129:0] r_acc;
    logic [127:0] r_buf;
    logic [4:0]   r_cnt;
    logic         r_last;
    logic [127:0] r_tag;
    logic [127:0] r_pb_r;
    logic [128:0] r_pb_m;
    logic [129:0] r_pb_a_in;

    logic [2:0]   w_eff_bytes;
    logic [4:0]   w_cnt_next;
    logic [127:0] w_buf_next;
    logic         w_block_done;
    logic [127:0] w_tag;

    // Merge the incoming word into the block buffer; short or oversized counts on
    // non-final words are forced to 4 so the byte offset stays word aligned.
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        w_eff_bytes = (!bus.msg_last || bus.msg_bytes > 3'd4) ? 3'd4 : bus.msg_bytes;
        w_cnt_next  = r_cnt + {2'b00, w_eff_bytes};
        w_buf_next  = r_buf;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(w_eff_bytes)) begin
                w_buf_next[{r_cnt[3:0] + 4'(k), 3'b000} +: 8] = bus.msg_data[8*k +: 8];
            end
        end
    end

    assign w_block_done = (w_cnt_next == 5'(BLOCK_BYTES)) || bus.msg_last;

    poly1305_finalize u_finalize (
        .i_acc (r_acc),
        .i_s   (r_s),
        .o_tag (w_tag)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_r       <= '0;
            r_s       <= '0;
            r_acc     <= '0;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_last    <= 1'b0;
            r_tag     <= '0;
            r_pb_r    <= '0;
            r_pb_m    <= '0;
            r_pb_a_in <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.key_valid) begin
                        r_r     <= bus.key_r & CLAMP_MASK;
                        r_s     <= bus.key_s;
                        r_acc   <= '0;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                        r_last  <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.msg_valid) begin
                        r_buf  <= w_buf_next;
                        r_cnt  <= w_cnt_next;
                        r_last <= bus.msg_last;
                        if (w_block_done) begin
                            // Nothing buffered at msg_last: the previous block already closed the message.
                            if (w_cnt_next == 5'd0) begin
                                r_state <= S_FINAL;
                            end else begin
                                r_pb_m    <= pad_block(w_buf_next, w_cnt_next);
                                r_pb_r    <= r_r;
                                r_pb_a_in <= r_acc;
                                r_state   <= S_START;
                            end
                        end
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.pb_done) begin
                        r_acc <= bus.pb_a_out;
                        if (r_last) begin
                            r_state <= S_FINAL;
                        end else begin
                            r_buf   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_FINAL: begin
                    r_tag   <= w_tag;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (bus.tag_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.key_ready = (r_state == S_IDLE);
    assign bus.msg_ready = (r_state == S_LOAD);
    assign bus.pb_start  = (r_state == S_START);
    assign bus.tag_valid = (r_state == S_OUT);
    assign bus.tag       = r_tag;
    assign bus.pb_r      = r_pb_r;
    assign bus.pb_m      = r_pb_m;
    assign bus.pb_a_in   = r_pb_a_in;

endmodule

// File: tb/tb_poly1305_sequencer.sv
// Directed bench for poly1305_sequencer with a behavioural processblock and a tag scoreboard.
module tb_poly1305_sequencer;

    localparam logic [129:0] P_TB      = 130'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
    localparam logic [127:0] RFC_R     = 128'ha806d542_fe52447f_336d5557_78bed685;
    localparam logic [127:0] RFC_R_CLM = 128'h0806d540_0e52447c_036d5554_08bed685;
    localparam logic [127:0] RFC_S     = 128'h1bf54941_aff6bf4a_fdb20dfb_8a800301;
    localparam logic [127:0] RFC_TAG   = 128'ha927010c_af8b2bc2_c6365130_c11d06a8;
    localparam logic [127:0] S_EMPTY   = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] S_ZERO_R  = 128'hdeadbeef_00112233_44556677_8899aabb;
    localparam logic [127:0] S_OTHER   = 128'h55555555_55555555_55555555_55555555;
    localparam logic [127:0] S_A       = 128'h0a0a0a0a_1b1b1b1b_2c2c2c2c_3d3d3d3d;
    localparam logic [127:0] S_B       = 128'hf0e0d0c0_b0a09080_70605040_30201000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    poly1305_sequencer_if bus ();

    poly1305_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [127:0] exp_q[$];
    byte unsigned msg_q[$];
    string        rfc_msg = "Cryptographic Forum Research Group";

    int           pb_starts = 0;
    logic         pb_busy;
    int           pb_cnt;
    logic [128:0] lat_m;
    logic [129:0] lat_a;
    logic [127:0] lat_r;
    logic         last_m_top;

    task automatic check(input string name, input logic [129:0] obs, input logic [129:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: observed no handshake expected handshake within bound", name);
    endtask

    // Reference block step; congruent results below 5 are lifted by P so the
    // sequencer sees the non-canonical accumulators a lazy processblock may return.
    function automatic logic [129:0] model_pb(input logic [129:0] a, input logic [128:0] m,
                                              input logic [127:0] r);
        logic [259:0] prod;
        logic [259:0] y;
        prod = (260'(a) + 260'(m)) * 260'(r);
        y    = prod % 260'(P_TB);
        if (y < 260'd5) y = y + 260'(P_TB);
        return y[129:0];
    endfunction

    // processblock stand-in: done one cycle, six cycles after the start cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pb_done  <= 1'b0;
            bus.pb_a_out <= '0;
            pb_busy      <= 1'b0;
            pb_cnt       <= 0;
        end else begin
            bus.pb_done <= 1'b0;
            if (bus.pb_start) begin
                pb_starts    <= pb_starts + 1;
                lat_m        <= bus.pb_m;
                lat_a        <= bus.pb_a_in;
                lat_r        <= bus.pb_r;
                last_m_top   <= bus.pb_m[128];
                bus.pb_a_out <= model_pb(bus.pb_a_in, bus.pb_m, bus.pb_r);
                pb_busy      <= 1'b1;
                pb_cnt       <= 5;
            end else if (pb_busy) begin
                if (pb_cnt == 1) begin
                    bus.pb_done <= 1'b1;
                    pb_busy     <= 1'b0;
                    check("pb_m_stable", 130'(bus.pb_m), 130'(lat_m));
                    check("pb_a_in_stable", bus.pb_a_in, lat_a);
                    check("pb_r_stable", 130'(bus.pb_r), 130'(lat_r));
                end
                pb_cnt <= pb_cnt - 1;
            end
        end
    end

    function automatic int nwords();
        return (msg_q.size() + 3) / 4;
    endfunction

    function automatic logic [31:0] word_data(input int w);
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            if (4*w + k < msg_q.size()) d[8*k +: 8] = msg_q[4*w + k];
        end
        return d;
    endfunction

    function automatic logic [2:0] word_bytes(input int w);
        int rem;
        rem = msg_q.size() - 4*w;
        return (rem >= 4) ? 3'd4 : 3'(rem);
    endfunction

    task automatic load_string(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    // All driver tasks are entered and left on a falling edge.
    task automatic send_key(input logic [127:0] r, input logic [127:0] s);
        int t;
        t = 0;
        bus.key_r     = r;
        bus.key_s     = s;
        bus.key_valid = 1'b1;
        while (!bus.key_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.key_ready) timeout_fail("key_timeout");
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int t;
        t = 0;
        bus.msg_data  = d;
        bus.msg_bytes = nb;
        bus.msg_last  = last;
        bus.msg_valid = 1'b1;
        while (!bus.msg_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.msg_ready) timeout_fail("msg_timeout");
        @(negedge clk);
        bus.msg_valid = 1'b0;
        bus.msg_last  = 1'b0;
    endtask

    task automatic send_words(input int w_from, input int w_to);
        for (int w = w_from; w < w_to; w++) begin
            send_word(word_data(w), word_bytes(w), (4*w + 4 >= msg_q.size()));
        end
    endtask

    task automatic wait_and_compare(input string name);
        int t;
        logic [127:0] exp;
        t = 0;
        while (!bus.tag_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (!bus.tag_valid) timeout_fail({name, "_timeout"});
        else check(name, 130'(bus.tag), 130'(exp));
    endtask

    task automatic get_tag(input string name, input int hold);
        logic [127:0] first;
        wait_and_compare(name);
        first = bus.tag;
        repeat (hold) begin
            @(negedge clk);
            check({name, "_hold_valid"}, 130'(bus.tag_valid), 130'd1);
            check({name, "_hold_tag"}, 130'(bus.tag), 130'(first));
        end
        bus.tag_ready = 1'b1;
        @(negedge clk);
        bus.tag_ready = 1'b0;
        check({name, "_back_idle"}, 130'(bus.key_ready), 130'd1);
    endtask

    initial begin
        int s0;
        #500000;
        $display("FAIL watchdog: observed no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        bus.key_valid = 1'b0;
        bus.key_r     = '0;
        bus.key_s     = '0;
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        bus.msg_bytes = '0;
        bus.msg_last  = 1'b0;
        bus.tag_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_key_ready", 130'(bus.key_ready), 130'd1);
        check("rst_msg_ready", 130'(bus.msg_ready), 130'd0);
        check("rst_tag_valid", 130'(bus.tag_valid), 130'd0);
        check("rst_pb_start", 130'(bus.pb_start), 130'd0);
        check("rst_tag", 130'(bus.tag), 130'd0);
        reset = 1'b0;
        @(negedge clk);

        // RFC 8439 vector: 34 bytes -> three blocks, last one partial.
        s0 = pb_starts;
        send_key(RFC_R, RFC_S);
        load_string(rfc_msg);
        send_words(0, nwords());
        exp_q.push_back(RFC_TAG);
        get_tag("rfc_tag", 0);
        check("rfc_starts", 130'(pb_starts - s0), 130'd3);
        check("rfc_pb_r_clamped", 130'(bus.pb_r), 130'(RFC_R_CLM));

        // Empty message: tag is s, processblock never started.
        s0 = pb_starts;
        send_key(RFC_R, S_EMPTY);
        send_word(32'h0, 3'd0, 1'b1);
        exp_q.push_back(S_EMPTY);
        get_tag("empty_tag", 0);
        check("empty_starts", 130'(pb_starts - s0), 130'd0);

        // r=1, s=0, 32 bytes of 0xff with malformed byte counts -> acc = 2^130-2, tag 3.
        s0 = pb_starts;
        send_key(128'd1, 128'd0);
        send_word(32'hffff_ffff, 3'd3, 1'b0);
        send_word(32'hffff_ffff, 3'd7, 1'b0);
        repeat (5) send_word(32'hffff_ffff, 3'd4, 1'b0);
        send_word(32'hffff_ffff, 3'd5, 1'b1);
        exp_q.push_back(128'd3);
        get_tag("reduce_tag", 0);
        check("reduce_starts", 130'(pb_starts - s0), 130'd2);

        // Message ends on a block boundary, then an empty last word.
        s0 = pb_starts;
        send_key(128'd1, 128'd0);
        repeat (4) send_word(32'hffff_ffff, 3'd4, 1'b0);
        send_word(32'h0, 3'd0, 1'b1);
        exp_q.push_back({128{1'b1}});
        get_tag("boundary_tag", 0);
        check("boundary_starts", 130'(pb_starts - s0), 130'd1);

        // Exactly 16 bytes with r=0; a second key offered during LOAD must be ignored.
        s0 = pb_starts;
        send_key(128'd0, S_ZERO_R);
        bus.key_r     = RFC_R;
        bus.key_s     = S_OTHER;
        bus.key_valid = 1'b1;
        @(negedge clk);
        check("load_key_ready", 130'(bus.key_ready), 130'd0);
        check("load_msg_ready", 130'(bus.msg_ready), 130'd1);
        @(negedge clk);
        bus.key_valid = 1'b0;
        msg_q.delete();
        for (int i = 0; i < 16; i++) msg_q.push_back(byte'(8'h11 * i));
        send_words(0, 4);
        exp_q.push_back(S_ZERO_R);
        get_tag("r0_tag", 0);
        check("r0_starts", 130'(pb_starts - s0), 130'd1);
        check("r0_pad_bit", 130'(last_m_top), 130'd1);

        // RFC again with a word held during START/WAIT and tag_ready held low.
        send_key(RFC_R, RFC_S);
        load_string(rfc_msg);
        send_words(0, 4);
        bus.msg_data  = word_data(4);
        bus.msg_bytes = word_bytes(4);
        bus.msg_last  = 1'b0;
        bus.msg_valid = 1'b1;
        repeat (4) begin
            check("stall_msg_ready", 130'(bus.msg_ready), 130'd0);
            @(negedge clk);
        end
        send_words(4, nwords());
        exp_q.push_back(RFC_TAG);
        get_tag("stall_tag", 5);

        // key_valid together with tag_ready in OUT: key taken one cycle later.
        send_key(RFC_R, S_A);
        send_word(32'h0, 3'd0, 1'b1);
        exp_q.push_back(S_A);
        wait_and_compare("out_key_tag_a");
        bus.key_r     = RFC_R;
        bus.key_s     = S_B;
        bus.key_valid = 1'b1;
        bus.tag_ready = 1'b1;
        @(negedge clk);
        bus.tag_ready = 1'b0;
        check("out_key_ignored", 130'(bus.key_ready), 130'd1);
        @(negedge clk);
        check("out_key_taken", 130'(bus.key_ready), 130'd0);
        bus.key_valid = 1'b0;
        send_word(32'h0, 3'd0, 1'b1);
        exp_q.push_back(S_B);
        get_tag("out_key_tag_b", 0);

        // Asynchronous reset while processblock is busy.
        send_key(RFC_R, RFC_S);
        load_string(rfc_msg);
        send_words(0, 4);
        @(negedge clk);
        check("pre_rst_in_wait", 130'(bus.msg_ready | bus.key_ready | bus.pb_start), 130'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_key_ready", 130'(bus.key_ready), 130'd1);
        check("arst_tag_valid", 130'(bus.tag_valid), 130'd0);
        check("arst_pb_start", 130'(bus.pb_start), 130'd0);
        check("arst_msg_ready", 130'(bus.msg_ready), 130'd0);
        check("arst_pb_m", 130'(bus.pb_m), 130'd0);
        check("arst_pb_a_in", bus.pb_a_in, 130'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_no_tag", 130'(bus.tag_valid), 130'd0);
        check("post_rst_idle", 130'(bus.key_ready), 130'd1);

        s0 = pb_starts;
        send_key(RFC_R, RFC_S);
        send_words(0, nwords());
        exp_q.push_back(RFC_TAG);
        get_tag("post_rst_tag", 0);
        check("post_rst_starts", 130'(pb_starts - s0), 130'd3);

        check("scoreboard_empty", 130'(exp_q.size()), 130'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
